// File: rtl/db9_pkg.sv
// Shared definitions for the DB9 Mega Drive pad scanner.
// Holds the button bit map, the pad type and FSM state enums, the phase
// count, and the helpers that turn one scan into a committed button word.
package db9_pkg;

  // Bit positions in the active-high button word
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  // SELECT half-periods per port scan
  localparam int NUM_PHASES = 8;

  typedef enum logic [1:0] {
    PAD_NONE = 2'd0,
    PAD_MD3  = 2'd1,
    PAD_MD6  = 2'd2
  } pad_type_e;

  typedef enum logic [1:0] {
    ST_SPLIT_SETTLE = 2'd0,
    ST_PHASE        = 2'd1,
    ST_IDLE         = 2'd2
  } state_e;

  // Mask the scratch word down to the buttons the detected pad type really has
  function automatic logic [15:0] resolve_word(input logic [11:0] scr,
                                               input logic        md_seen,
                                               input logic        six_seen);
    logic [15:0] w;
    w = {4'b0000, scr};
    if (!md_seen) begin
      w[11:6] = 6'b000000;
    end else if (!six_seen) begin
      w[11:8] = 4'b0000;
    end
    return w;
  endfunction

  function automatic pad_type_e resolve_type(input logic md_seen,
                                             input logic six_seen);
    if (!md_seen) begin
      return PAD_NONE;
    end else if (!six_seen) begin
      return PAD_MD3;
    end
    return PAD_MD6;
  endfunction

  // A bit follows the new scan only when it matches the previous scan;
  // otherwise the currently shown value is kept
  function automatic logic [15:0] debounce_merge(input logic [15:0] held,
                                                 input logic [15:0] prev,
                                                 input logic [15:0] cur);
    logic [15:0] agree;
    agree = ~(prev ^ cur);
    return (cur & agree) | (held & ~agree);
  endfunction

endpackage

// File: rtl/db9_sync.sv
// Two-flop synchronizer for the raw pad lines. Resets to all ones, which is
// the idle (released) level of the active-low pad inputs.
module db9_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values simply shift the input down the chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/db9_md_pad_scanner.sv
// Scans two DB9 Mega Drive / Atari pads that share one 6-bit input bus.
// Each port scan: settle after switching the port mux, eight SELECT
// half-periods with sampling, then a long SELECT-high idle so 6-button pads
// reset their internal counter. The decoded word commits at idle entry.
// Optional build macro: DB9_DEBOUNCE_EN -- a button bit only changes when
// two consecutive scans of its port agree on it.
module db9_md_pad_scanner
  import db9_pkg::*;
#(
  parameter int PHASE_CYC = 512,
  parameter int IDLE_CYC  = 131072,
  parameter int SPLIT_CYC = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad_type1,
  output logic [1:0]  pad_type2,
  output logic        scan_strobe
);

  localparam int MAX_CYC = (IDLE_CYC > PHASE_CYC)
                         ? ((IDLE_CYC > SPLIT_CYC) ? IDLE_CYC : SPLIT_CYC)
                         : ((PHASE_CYC > SPLIT_CYC) ? PHASE_CYC : SPLIT_CYC);
  localparam int CNT_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SPLIT_LAST = CNT_W'(SPLIT_CYC - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_PHASES - 1);

  logic [5:0] joy_sync;
  logic [5:0] act;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             split_q, split_d;
  logic             mdsel_q, mdsel_d;
  logic [11:0]      scratch_q, scratch_d;
  logic             md_seen_q, md_seen_d;
  logic             six_seen_q, six_seen_d;
  logic [15:0]      js1_q, js1_d;
  logic [15:0]      js2_q, js2_d;
  pad_type_e        pt1_q, pt1_d;
  pad_type_e        pt2_q, pt2_d;
  logic             strobe_q, strobe_d;
  logic [15:0]      commit_word;
  pad_type_e        commit_type;
`ifdef DB9_DEBOUNCE_EN
  logic [15:0]      prev1_q, prev1_d;
  logic [15:0]      prev2_q, prev2_d;
`endif

  db9_sync #(.WIDTH(6)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (joy_in),
    .q       (joy_sync)
  );

  // Pad lines are active low; work with pressed = 1
  assign act = ~joy_sync;

  // Scan sequencer: next state, sampling into the scratch word, and commit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    split_d     = split_q;
    mdsel_d     = mdsel_q;
    scratch_d   = scratch_q;
    md_seen_d   = md_seen_q;
    six_seen_d  = six_seen_q;
    js1_d       = js1_q;
    js2_d       = js2_q;
    pt1_d       = pt1_q;
    pt2_d       = pt2_q;
    strobe_d    = 1'b0;
    commit_word = resolve_word(scratch_q, md_seen_q, six_seen_q);
    commit_type = resolve_type(md_seen_q, six_seen_q);
`ifdef DB9_DEBOUNCE_EN
    prev1_d     = prev1_q;
    prev2_d     = prev2_q;
`endif

    unique case (state_q)
      ST_SPLIT_SETTLE: begin
        if (cnt_q == SPLIT_LAST) begin
          state_d = ST_PHASE;
          cnt_d   = '0;
          idx_d   = 3'd0;
          mdsel_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PHASE: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d = '0;
          // Sample on the last cycle of the phase, when the pad has settled
          unique case (idx_q)
            3'd0: begin
              scratch_d[BTN_R] = act[0];
              scratch_d[BTN_L] = act[1];
              scratch_d[BTN_D] = act[2];
              scratch_d[BTN_U] = act[3];
              scratch_d[BTN_B] = act[4];
              scratch_d[BTN_C] = act[5];
            end
            3'd1: begin
              scratch_d[BTN_A]     = act[4];
              scratch_d[BTN_START] = act[5];
              // Left+right both low with SELECT low is the MD pad signature
              md_seen_d = act[0] & act[1];
            end
            3'd5: begin
              // Third SELECT-low: a 6-button pad pulls all directions low
              six_seen_d = &act[3:0];
            end
            3'd6: begin
              if (six_seen_q) begin
                scratch_d[BTN_Z]    = act[3];
                scratch_d[BTN_Y]    = act[2];
                scratch_d[BTN_X]    = act[1];
                scratch_d[BTN_MODE] = act[0];
              end
            end
            default: ;
          endcase

          if (idx_q == LAST_IDX) begin
            state_d  = ST_IDLE;
            mdsel_d  = 1'b1;
            strobe_d = 1'b1;
`ifdef DB9_DEBOUNCE_EN
            if (!split_q) begin
              js1_d   = debounce_merge(js1_q, prev1_q, commit_word);
              prev1_d = commit_word;
              pt1_d   = commit_type;
            end else begin
              js2_d   = debounce_merge(js2_q, prev2_q, commit_word);
              prev2_d = commit_word;
              pt2_d   = commit_type;
            end
`else
            if (!split_q) begin
              js1_d = commit_word;
              pt1_d = commit_type;
            end else begin
              js2_d = commit_word;
              pt2_d = commit_type;
            end
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            mdsel_d = ~idx_d[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_IDLE: begin
        if (cnt_q == IDLE_LAST) begin
          state_d    = ST_SPLIT_SETTLE;
          cnt_d      = '0;
          split_d    = ~split_q;
          mdsel_d    = 1'b1;
          scratch_d  = '0;
          md_seen_d  = 1'b0;
          six_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_SPLIT_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, scratch and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SPLIT_SETTLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      split_q    <= 1'b0;
      mdsel_q    <= 1'b1;
      scratch_q  <= '0;
      md_seen_q  <= 1'b0;
      six_seen_q <= 1'b0;
      js1_q      <= '0;
      js2_q      <= '0;
      pt1_q      <= PAD_NONE;
      pt2_q      <= PAD_NONE;
      strobe_q   <= 1'b0;
`ifdef DB9_DEBOUNCE_EN
      prev1_q    <= '0;
      prev2_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      split_q    <= split_d;
      mdsel_q    <= mdsel_d;
      scratch_q  <= scratch_d;
      md_seen_q  <= md_seen_d;
      six_seen_q <= six_seen_d;
      js1_q      <= js1_d;
      js2_q      <= js2_d;
      pt1_q      <= pt1_d;
      pt2_q      <= pt2_d;
      strobe_q   <= strobe_d;
`ifdef DB9_DEBOUNCE_EN
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
`endif
    end
  end

  assign joy_mdsel   = mdsel_q;
  assign joy_split   = split_q;
  assign joystick1   = js1_q;
  assign joystick2   = js2_q;
  assign pad_type1   = pt1_q;
  assign pad_type2   = pt2_q;
  assign scan_strobe = strobe_q;

endmodule

// File: tb/tb_db9_md_pad_scanner.sv
// Self-checking bench for db9_md_pad_scanner with small cycle parameters.
// Behavioural pad models (unplugged, Atari, MD3, MD6) drive joy_in through
// the port mux; a cycle-position reference model predicts every output.
module tb_db9_md_pad_scanner;

  localparam int P      = 4;
  localparam int I      = 64;
  localparam int S      = 4;
  localparam int L      = S + 8 * P + I;
  localparam int COMMIT = S + 8 * P;

  // pad kinds
  localparam int PK_NONE  = 0;
  localparam int PK_ATARI = 1;
  localparam int PK_MD3   = 2;
  localparam int PK_MD6   = 3;

  logic        clk;
  logic        reset_n;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  pad_type1;
  logic [1:0]  pad_type2;
  logic        scan_strobe;

  int checks = 0;
  int errors = 0;

  int          p1_typ, p2_typ;
  logic [11:0] p1_btn, p2_btn;

  db9_md_pad_scanner #(
    .PHASE_CYC (P),
    .IDLE_CYC  (I),
    .SPLIT_CYC (S)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joy_in      (joy_in),
    .joy_mdsel   (joy_mdsel),
    .joy_split   (joy_split),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .pad_type1   (pad_type1),
    .pad_type2   (pad_type2),
    .scan_strobe (scan_strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- pad models ----------------
  // Shared SELECT line: one MD6 edge counter, reset after 32 quiet clocks
  logic sel_prev = 1'b1;
  int   md6_cnt  = 0;
  int   sel_idle = 0;

  always @(posedge clk) begin
    sel_prev <= joy_mdsel;
    if (sel_prev != joy_mdsel) begin
      sel_idle <= 0;
      if (sel_prev && !joy_mdsel) md6_cnt <= md6_cnt + 1;
    end else begin
      if (sel_idle == 31) md6_cnt <= 0;
      if (sel_idle < 1000) sel_idle <= sel_idle + 1;
    end
  end

  // btn bits: R0 L1 D2 U3 B4 C5 A6 St7 Mo8 X9 Y10 Z11 (1 = pressed)
  function automatic logic [5:0] pad_lines(input int typ, input logic [11:0] b,
                                           input logic sel, input int cnt);
    logic [5:0] hi_std, lo_std;
    hi_std = ~{b[5], b[4], b[3], b[2], b[1], b[0]};
    lo_std = {~b[7], ~b[6], ~b[3], ~b[2], 2'b00};
    case (typ)
      PK_ATARI: return hi_std;
      PK_MD3:   return sel ? hi_std : lo_std;
      PK_MD6: begin
        if (sel) begin
          if (cnt == 3) return {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]};
          return hi_std;
        end
        if (cnt == 3) return {~b[7], ~b[6], 4'b0000};
        if (cnt == 4) return {~b[7], ~b[6], 4'b1111};
        return lo_std;
      end
      default:  return 6'h3F;
    endcase
  endfunction

  always_comb begin
    joy_in = joy_split ? pad_lines(p2_typ, p2_btn, joy_mdsel, md6_cnt)
                       : pad_lines(p1_typ, p1_btn, joy_mdsel, md6_cnt);
  end

  // ---------------- reference model ----------------
  // n = cycles since reset release; hist[m] = joy_in seen at the end of scan cycle m
  int         n;
  logic [5:0] hist [0:L-1];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n <= 0;
    end else begin
      hist[n % L] <= joy_in;
      n <= n + 1;
    end
  end

  // Each phase samples the line state two cycles before its last cycle
  function automatic logic [5:0] pressed_at(input int idx);
    return ~hist[S + idx * P + P - 3];
  endfunction

  task automatic ref_scan(output logic [15:0] w, output logic [1:0] t);
    logic [5:0] a0, a1, a5, a6;
    logic md, six;
    a0 = pressed_at(0);
    a1 = pressed_at(1);
    a5 = pressed_at(5);
    a6 = pressed_at(6);
    w = 16'h0000;
    w[5:0] = a0;                 // R L D U B C in line order
    w[6] = a1[4];
    w[7] = a1[5];
    md  = a1[0] & a1[1];
    six = &a5[3:0];
    if (six) w[11:8] = {a6[3], a6[2], a6[1], a6[0]};
    if (!md) begin
      w[11:6] = 6'b0; t = 2'd0;
    end else if (!six) begin
      w[11:8] = 4'b0; t = 2'd1;
    end else begin
      t = 2'd2;
    end
  endtask

  logic [15:0] ej [2];
  logic [15:0] eprev [2];
  logic [1:0]  et [2];

  initial begin
    int m, port, idx;
    logic emd, estb;
    logic [15:0] w;
    logic [1:0] t;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int k = 0; k < 2; k++) begin
          ej[k] = 16'h0; eprev[k] = 16'h0; et[k] = 2'd0;
        end
        chk("rst_mdsel", 32'(joy_mdsel), 32'd1);
        chk("rst_split", 32'(joy_split), 32'd0);
        chk("rst_js1", 32'(joystick1), 32'd0);
        chk("rst_js2", 32'(joystick2), 32'd0);
        chk("rst_strobe", 32'(scan_strobe), 32'd0);
      end else begin
        m    = n % L;
        port = (n / L) % 2;
        if (m >= S && m < COMMIT) begin
          idx = (m - S) / P;
          emd = (idx % 2 == 0);
        end else begin
          emd = 1'b1;
        end
        estb = (m == COMMIT);
        if (estb) begin
          ref_scan(w, t);
`ifdef DB9_DEBOUNCE_EN
          ej[port] = (w & ~(eprev[port] ^ w)) | (ej[port] & (eprev[port] ^ w));
          eprev[port] = w;
`else
          ej[port] = w;
`endif
          et[port] = t;
        end
        chk("mdsel", 32'(joy_mdsel), 32'(emd));
        chk("split", 32'(joy_split), 32'(port));
        chk("strobe", 32'(scan_strobe), 32'(estb));
        chk("joystick1", 32'(joystick1), 32'(ej[0]));
        chk("joystick2", 32'(joystick2), 32'(ej[1]));
        chk("pad_type1", 32'(pad_type1), 32'(et[0]));
        chk("pad_type2", 32'(pad_type2), 32'(et[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_commit(input int port);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3 * L && !got; k++) begin
      @(negedge clk);
      if (scan_strobe === 1'b1 && joy_split === 1'(port)) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_commit: port%0d strobe seen=%0d required=1 within %0d cycles", port + 1, got, 3 * L);
    end
  endtask

  initial begin
    bit got;
    reset_n = 1'b0;
    p1_typ = PK_MD6;  p1_btn = 12'h940;   // A, Z, Mode
    p2_typ = PK_NONE; p2_btn = 12'h000;
    repeat (3) @(negedge clk);
    chk("lit_reset_js1", 32'(joystick1), 32'h0);
    chk("lit_reset_pt1", 32'(pad_type1), 32'd0);
    chk("lit_reset_mdsel", 32'(joy_mdsel), 32'd1);
    #1 reset_n = 1'b1;

    // MD6 on port 1, port 2 unplugged
    wait_commit(0);
    wait_commit(0);
    chk("lit_md6_js1", 32'(joystick1), 32'h0940);
    chk("lit_md6_pt1", 32'(pad_type1), 32'd2);
    chk("lit_md6_js2", 32'(joystick2), 32'h0);

    // MD3 on port 2 with Start+Up, port 1 unplugged
    p1_typ = PK_NONE; p1_btn = 12'h000;
    p2_typ = PK_MD3;  p2_btn = 12'h088;
    wait_commit(1);
    wait_commit(1);
    wait_commit(0);
    chk("lit_md3_js2", 32'(joystick2), 32'h0088);
    chk("lit_md3_pt2", 32'(pad_type2), 32'd1);
    chk("lit_unplug_js1", 32'(joystick1), 32'h0);
    chk("lit_unplug_pt1", 32'(pad_type1), 32'd0);

    // Atari pad: fire (pin6) and right
    p1_typ = PK_ATARI; p1_btn = 12'h011;
    wait_commit(0);
    wait_commit(0);
    chk("lit_atari_js1", 32'(joystick1), 32'h0011);
    chk("lit_atari_pt1", 32'(pad_type1), 32'd0);

    // Hot-swap MD6 -> MD3 between scans
    p1_typ = PK_MD6; p1_btn = 12'h940;
    wait_commit(0);
    wait_commit(0);
    chk("lit_swap_pre_pt1", 32'(pad_type1), 32'd2);
    p1_typ = PK_MD3;
    wait_commit(0);
    chk("lit_swap_pt1", 32'(pad_type1), 32'd1);
`ifndef DB9_DEBOUNCE_EN
    chk("lit_swap_hi_bits", 32'(joystick1[11:8]), 32'h0);
`endif
    wait_commit(0);
    chk("lit_swap_js1", 32'(joystick1), 32'h0040);

    // Single-scan glitch on B, then B held for two scans
    p1_typ = PK_ATARI; p1_btn = 12'h000;
    wait_commit(0);
    wait_commit(0);
    p1_btn = 12'h010;
    wait_commit(0);
`ifdef DB9_DEBOUNCE_EN
    chk("lit_glitch_b", 32'(joystick1[4]), 32'd0);
`else
    chk("lit_glitch_b", 32'(joystick1[4]), 32'd1);
`endif
    p1_btn = 12'h000;
    wait_commit(0);
    chk("lit_glitch_gone", 32'(joystick1[4]), 32'd0);
    p1_btn = 12'h010;
    wait_commit(0);
`ifdef DB9_DEBOUNCE_EN
    chk("lit_hold_b1", 32'(joystick1[4]), 32'd0);
`else
    chk("lit_hold_b1", 32'(joystick1[4]), 32'd1);
`endif
    wait_commit(0);
    chk("lit_hold_b2", 32'(joystick1[4]), 32'd1);

    // Randomized pads and buttons
    for (int r = 0; r < 10; r++) begin
      p1_typ = $urandom_range(0, 3);
      p2_typ = $urandom_range(0, 3);
      p1_btn = 12'($urandom);
      p2_btn = 12'($urandom);
      repeat ($urandom_range(1, 3)) wait_commit($urandom_range(0, 1));
    end

    // Reset during idx4 of a port-2 scan
    p1_typ = PK_MD3; p1_btn = 12'($urandom);
    p2_typ = PK_MD6; p2_btn = 12'($urandom);
    wait_commit(0);
    repeat (I + S + 4 * P + 1) @(negedge clk);
    chk("lit_pre_reset_split", 32'(joy_split), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("lit_async_js1", 32'(joystick1), 32'h0);
    chk("lit_async_js2", 32'(joystick2), 32'h0);
    chk("lit_async_pt", 32'({pad_type1, pad_type2}), 32'h0);
    chk("lit_async_mdsel", 32'(joy_mdsel), 32'd1);
    chk("lit_async_split", 32'(joy_split), 32'd0);
    chk("lit_async_strobe", 32'(scan_strobe), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 2 * L && !got; k++) begin
      @(negedge clk);
      if (scan_strobe === 1'b1) got = 1'b1;
    end
    chk("lit_post_reset_strobe", 32'(got), 32'd1);
    chk("lit_post_reset_port", 32'(joy_split), 32'd0);
    wait_commit(1);
    wait_commit(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
